// File: rtl/nios_memoria_arb_pkg.sv
// Shared types and defaults for the two-port on-chip RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_memoria_arb_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_BE_W     = DEF_DATA_W / 8;
    localparam int DEF_MAX_HOLD = 4;

    // Port identifiers as stored in last_owner.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_grant_fsm.sv
// Owner FSM: round-robin grant between two requesters with a bounded hold count.
// Latency: grant is combinational from the current requests (zero-wait when free).
// Backpressure: a non-granted requester is stalled; an owner yields after MAX_HOLD accepts under contention.
module ram_grant_fsm
    import nios_memoria_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              last_owner;
    logic              last_owner_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic              hold_ok;

    // Owner state, fairness history and hold counter; s0 wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= PORT1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    // Grant decision and next-state; every grant is an accept since grant implies request.
    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        state_nxt      = IDLE;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        hold_ok        = (hold_cnt < HOLD_LIM);

        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    if (last_owner == PORT1) grant0 = 1'b1;
                    else                     grant1 = 1'b1;
                end else if (req0) begin
                    grant0 = 1'b1;
                end else if (req1) begin
                    grant1 = 1'b1;
                end
            end
            OWN0: begin
                if (req0 && (!req1 || hold_ok)) grant0 = 1'b1;
                else if (req1)                  grant1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (!req0 || hold_ok)) grant1 = 1'b1;
                else if (req0)                  grant0 = 1'b1;
            end
            default: begin
            end
        endcase

        if (grant0) begin
            state_nxt = OWN0;
            if (state != OWN0) begin
                hold_cnt_nxt   = HOLD_W'(1);
                last_owner_nxt = PORT0;
            end else if (hold_ok) begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end else if (grant1) begin
            state_nxt = OWN1;
            if (state != OWN1) begin
                hold_cnt_nxt   = HOLD_W'(1);
                last_owner_nxt = PORT1;
            end else if (hold_ok) begin
                hold_cnt_nxt = hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_memoria_arbiter.sv
// Shares one single-port 1-cycle-latency RAM between the Nios data master (s0) and the pong engine (s1).
// Latency: zero-wait request path; readdatavalid one cycle after the accepted read.
// Backpressure: waitrequest to the non-granted requester only; read responses never stall.
module nios_memoria_arbiter
    import nios_memoria_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic [BE_W-1:0]   s0_byteenable,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic [BE_W-1:0]   s1_byteenable,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] m_address,
    output logic [BE_W-1:0]   m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic rvalid0;
    logic rvalid1;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    ram_grant_fsm #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .grant0  (grant0),
        .grant1  (grant1)
    );

    assign s0_waitrequest = req0 & ~grant0;
    assign s1_waitrequest = req1 & ~grant1;

    // s0 is the default mux leg; chipselect alone marks an idle RAM cycle.
    assign m_chipselect = grant0 | grant1;
    assign m_address    = grant1 ? s1_address    : s0_address;
    assign m_byteenable = grant1 ? s1_byteenable : s0_byteenable;
    assign m_writedata  = grant1 ? s1_writedata  : s0_writedata;
    assign m_write      = grant1 ? s1_write      : (grant0 & s0_write);

    // Response steering: remember which port issued a pure read last cycle (read+write counts as write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= grant0 & s0_read & ~s0_write;
            rvalid1 <= grant1 & s1_read & ~s1_write;
        end
    end

    assign s0_readdatavalid = rvalid0;
    assign s1_readdatavalid = rvalid1;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

endmodule

// File: tb/tb_nios_memoria_arbiter.sv
module tb_nios_memoria_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] s0_address, s1_address;
    logic [BE_W-1:0]   s0_byteenable, s1_byteenable;
    logic              s0_read, s1_read, s0_write, s1_write;
    logic [DATA_W-1:0] s0_writedata, s1_writedata;
    logic              s0_waitrequest, s1_waitrequest;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_chipselect, m_write;
    logic [DATA_W-1:0] m_writedata, m_readdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_memoria_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
        .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
        .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    // RAM model: registered address, unregistered q, byte-enabled writes, bench preload port.
    logic [DATA_W-1:0] mem [0:1023];
    logic [ADDR_W-1:0] ram_addr_q = '0;
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] = pre_dat;
        end else if (m_chipselect) begin
            if (m_write)
                for (int b = 0; b < BE_W; b++)
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] = m_writedata[8*b +: 8];
            ram_addr_q = m_address;
        end
    end
    assign m_readdata = mem[ram_addr_q];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion before limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        s0_address = '0; s0_byteenable = 4'hF; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
        s1_address = '0; s1_byteenable = 4'hF; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_dat = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s0_waitrequest, s1_waitrequest, m_chipselect, m_write, s0_readdatavalid, s1_readdatavalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 000000",
                {s0_waitrequest, s1_waitrequest, m_chipselect, m_write, s0_readdatavalid, s1_readdatavalid});
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_rw();
        s0_write = 1'b1; s0_address = 10'h010; s0_byteenable = 4'hF; s0_writedata = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({s0_waitrequest, m_chipselect, m_write} !== 3'b011 || m_address !== 10'h010) begin
            errors++;
            $display("FAIL basic_write: wr/cs/we=%b addr=%h required 011 addr=010",
                {s0_waitrequest, m_chipselect, m_write}, m_address);
        end
        @(posedge clk); #1;
        s0_write = 1'b0; s0_read = 1'b1;
        @(negedge clk);
        checks++;
        if (s0_waitrequest !== 1'b0 || m_write !== 1'b0 || s0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_read_issue: wr=%b we=%b rdv=%b required 0 0 0",
                s0_waitrequest, m_write, s0_readdatavalid);
        end
        @(posedge clk); #1;
        s0_read = 1'b0;
        @(negedge clk);
        checks++;
        if (s0_readdatavalid !== 1'b1 || s0_readdata !== 32'hDEADBEEF || s1_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL basic_read_resp: rdv0=%b data=%h rdv1=%b required 1 deadbeef 0",
                s0_readdatavalid, s0_readdata, s1_readdatavalid);
        end
        @(posedge clk); #1;
        // read and write together behave as a write with no response
        s0_read = 1'b1; s0_write = 1'b1; s0_address = 10'h011; s0_writedata = 32'h00000005;
        @(negedge clk);
        checks++;
        if (s0_readdatavalid !== 1'b0 || m_write !== 1'b1) begin
            errors++;
            $display("FAIL basic_single_pulse: rdv0=%b we=%b required 0 1", s0_readdatavalid, m_write);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (s0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rw_both_no_resp: rdv0=%b required 0", s0_readdatavalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int a0 = 0, a1 = 0, exp_g, prev_g = -1;
        logic [DATA_W-1:0] prev_data = '0;
        apply_reset();
        s0_read = 1'b1; s1_read = 1'b1; s0_address = 10'h100; s1_address = 10'h200;
        for (int k = 0; k < 12; k++) begin
            exp_g = (k / 4) % 2;
            @(negedge clk);
            checks++;
            if (s0_waitrequest !== (exp_g != 0) || s1_waitrequest !== (exp_g != 1)) begin
                errors++;
                $display("FAIL rr_grant cycle %0d: wr0=%b wr1=%b required port %0d granted",
                    k, s0_waitrequest, s1_waitrequest, exp_g);
            end
            checks++;
            if (s0_readdatavalid !== (prev_g == 0) || s1_readdatavalid !== (prev_g == 1) ||
                (prev_g >= 0 && m_readdata !== prev_data)) begin
                errors++;
                $display("FAIL rr_resp cycle %0d: rdv0=%b rdv1=%b data=%h required port %0d data %h",
                    k, s0_readdatavalid, s1_readdatavalid, m_readdata, prev_g, prev_data);
            end
            prev_data = (exp_g == 0) ? 32'hA0000100 + a0 : 32'hB0000200 + a1;
            prev_g = exp_g;
            if (exp_g == 0) a0++; else a1++;
            @(posedge clk); #1;
            s0_address = 10'h100 + 10'(a0);
            s1_address = 10'h200 + 10'(a1);
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (s0_readdatavalid !== 1'b1 || s1_readdatavalid !== 1'b0 || s0_readdata !== prev_data) begin
            errors++;
            $display("FAIL rr_last_resp: rdv0=%b rdv1=%b data=%h required 1 0 %h",
                s0_readdatavalid, s1_readdatavalid, s0_readdata, prev_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_partial_write();
        s1_write = 1'b1; s1_address = 10'h040; s1_byteenable = 4'b0010; s1_writedata = 32'h0000AB00;
        @(negedge clk);
        checks++;
        if (s1_waitrequest !== 1'b0 || m_write !== 1'b1 || m_byteenable !== 4'b0010 || m_address !== 10'h040) begin
            errors++;
            $display("FAIL be_write: wr1=%b we=%b be=%b addr=%h required 0 1 0010 040",
                s1_waitrequest, m_write, m_byteenable, m_address);
        end
        @(posedge clk); #1;
        s1_write = 1'b0; s1_read = 1'b1; s1_byteenable = 4'hF;
        @(posedge clk); #1;
        s1_read = 1'b0;
        @(negedge clk);
        checks++;
        if (s1_readdatavalid !== 1'b1 || s1_readdata !== 32'h1122AB44 || s0_readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL be_merge: rdv1=%b data=%h rdv0=%b required 1 1122ab44 0",
                s1_readdatavalid, s1_readdata, s0_readdatavalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        logic [7:0] g_tab = 8'b0001_0000;
        int a0 = 0, exp_g, prev_g = -1, s1_wait = 0;
        logic [DATA_W-1:0] prev_data = '0;
        apply_reset();
        s0_read = 1'b1; s0_address = 10'h100; s1_address = 10'h205;
        for (int k = 0; k < 8; k++) begin
            exp_g = g_tab[k] ? 1 : 0;
            @(negedge clk);
            if (s1_waitrequest === 1'b1) s1_wait++;
            checks++;
            if (s0_waitrequest !== (exp_g != 0) || s1_waitrequest !== (s1_read && exp_g != 1)) begin
                errors++;
                $display("FAIL fair_grant cycle %0d: wr0=%b wr1=%b required port %0d granted",
                    k, s0_waitrequest, s1_waitrequest, exp_g);
            end
            checks++;
            if (s0_readdatavalid !== (prev_g == 0) || s1_readdatavalid !== (prev_g == 1) ||
                (prev_g >= 0 && m_readdata !== prev_data)) begin
                errors++;
                $display("FAIL fair_resp cycle %0d: rdv0=%b rdv1=%b data=%h required port %0d data %h",
                    k, s0_readdatavalid, s1_readdatavalid, m_readdata, prev_g, prev_data);
            end
            prev_data = (exp_g == 0) ? 32'hA0000100 + a0 : 32'hB0000205;
            prev_g = exp_g;
            if (exp_g == 0) a0++;
            @(posedge clk); #1;
            s0_address = 10'h100 + 10'(a0);
            if (k == 0) s1_read = 1'b1;
            if (exp_g == 1) s1_read = 1'b0;
        end
        clear_inputs();
        checks++;
        if (s1_wait > MAX_HOLD || s1_wait != 3 || a0 != 7) begin
            errors++;
            $display("FAIL fair_bound: s1 waited %0d s0 accepts %0d required 3 and 7", s1_wait, a0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_inflight();
        s1_read = 1'b1; s1_address = 10'h200;
        @(negedge clk);
        checks++;
        if (s1_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL inflight_accept: wr1=%b required 0", s1_waitrequest);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s1_readdatavalid !== 1'b0) begin
                errors++;
                $display("FAIL inflight_dropped cycle %0d: rdv1=%b required 0", k, s1_readdatavalid);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s0_waitrequest, s1_waitrequest, m_chipselect, m_write, s0_readdatavalid, s1_readdatavalid} !== 6'b0) begin
            errors++;
            $display("FAIL post_reset_outputs: got %b required 000000",
                {s0_waitrequest, s1_waitrequest, m_chipselect, m_write, s0_readdatavalid, s1_readdatavalid});
        end
        @(posedge clk); #1;
        s0_read = 1'b1; s1_read = 1'b1;
        @(negedge clk);
        checks++;
        if (s0_waitrequest !== 1'b0 || s1_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_contention: wr0=%b wr1=%b required 0 1", s0_waitrequest, s1_waitrequest);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 8; i++) begin
            preload(10'h100 + 10'(i), 32'hA0000100 + i);
            preload(10'h200 + 10'(i), 32'hB0000200 + i);
        end
        preload(10'h040, 32'h11223344);
        test_basic_rw();
        test_round_robin();
        test_partial_write();
        test_fairness();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_memoria_arbiter.md
Name: nios_memoria_arbiter

Overview:
- Two-port arbiter sharing one single-port on-chip RAM (1024x32, byte enables, registered address, unregistered q, 1-cycle read latency) between two Avalon-MM style requesters.
- Requesters: s0 = Nios data master, s1 = pong frame/score update engine.
- Round-robin arbitration with a bounded hold count, zero-wait grant when the RAM is free, and per-port read-response steering.
- Sits between the interconnect/engine and the RAM instance.

Parameters:
- ADDR_W, 10: word address width.
- DATA_W, 32: data width.
- BE_W, 4: byteenable width (DATA_W/8).
- MAX_HOLD, 4: maximum consecutive accepted transfers an owner may take while the other port waits. Legal range 1..15.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- s0_address / s1_address  in  ADDR_W  word address per port.
- s0_byteenable / s1_byteenable  in  BE_W  byte lanes per port.
- s0_read / s1_read  in  1  read request.
- s0_write / s1_write  in  1  write request.
- s0_writedata / s1_writedata  in  DATA_W  write data.
- s0_waitrequest / s1_waitrequest  out  1  stall; requester holds all inputs stable while high.
- s0_readdata / s1_readdata  out  DATA_W  read data, qualified by readdatavalid.
- s0_readdatavalid / s1_readdatavalid  out  1  one-cycle read response strobe.
- m_address  out  ADDR_W  to RAM address.
- m_byteenable  out  BE_W  to RAM byteenable.
- m_chipselect  out  1  to RAM chipselect.
- m_write  out  1  to RAM write.
- m_writedata  out  DATA_W  to RAM writedata.
- m_readdata  in  DATA_W  from RAM readdata (valid the cycle after the address is issued).

Behaviour:
- Request definition: reqX = sX_read | sX_write.
  - Accepted transfer: reqX & ~sX_waitrequest at a rising clk edge.
  - read and write both high on one port: treated as a write; no read response is generated.
- States (owner FSM): IDLE, OWN0, OWN1. Registered last_owner bit; hold_cnt counter of clog2(MAX_HOLD+1) bits.
- Grant is combinational, computed from current requests, state, last_owner and hold_cnt:
  - IDLE: one port requesting -> grant it. Both requesting -> grant ~last_owner.
  - OWNx: keep x if reqX && (!reqY || hold_cnt < MAX_HOLD). Otherwise grant y if reqY, else none.
  - Next state = OWN<granted port>, or IDLE if no grant.
  - On owner change: hold_cnt is set to 1 when the first transfer is accepted, and last_owner is set to the new owner.
  - On same-owner accept: hold_cnt increments, saturating at MAX_HOLD.
- Waitrequest: sX_waitrequest = reqX & ~grantX. It is 0 when the port is not requesting. An ungranted requester never sees a 1-cycle gap miss: grant switches to it no later than MAX_HOLD accepts after it asserts.
- RAM drive:
  - m_chipselect = grant0 | grant1.
  - m_write = granted port's write.
  - address/byteenable/writedata are muxed from the granted port.
  - No grant: mux selects s0, chipselect 0.
- Read path:
  - Registered rvalid0/rvalid1 = accepted read on that port in the previous cycle.
  - sX_readdatavalid = rvalidX.
  - s0_readdata = s1_readdata = m_readdata (combinational pass-through).
  - Back-to-back reads: one per cycle; alternating owners are allowed with no bubble.
- Simultaneous events:
  - Owner drops its request in the same cycle the other asserts -> the other is granted that cycle.
  - Write then read to the same address on consecutive cycles returns the new data. Same-cycle conflicts cannot occur (single port).
- Reset (async assert, sync deassert handled upstream): state IDLE, last_owner=1 (s0 wins first contention), hold_cnt=0, rvalid0/1=0.
  - All outputs go low: waitrequest low, m_chipselect 0, m_write 0, readdatavalid 0.
  - A read in flight when reset asserts is dropped and no readdatavalid is issued.

Decomposition:
- Package nios_memoria_arb_pkg:
  - ADDR_W/DATA_W/BE_W defaults.
  - State enum {IDLE, OWN0, OWN1}.
  - Port-id constants PORT0=0, PORT1=1.
- Sub-module ram_grant_fsm: owner FSM, last_owner and hold_cnt, producing grant0/grant1. The top level holds the muxes and the rvalid pipeline.

Test Plan:
- Reset release, s0 write 0xDEADBEEF @0x010 be=4'hF, then s0 read 0x010 -> zero waitrequest; s0_readdatavalid exactly 1 cycle after accept with 0xDEADBEEF; s1_readdatavalid stays 0.
- s0 and s1 both request reads from the first cycle after reset -> s0 granted first; with MAX_HOLD=4 and continuous requests, grant pattern is 4x s0, 4x s1, 4x s0; each readdatavalid lands on the correct port.
- s1 write be=4'b0010 data 0x0000AB00 to a word preloaded 0x11223344, then read -> 0x1122AB44.
- s0 continuous, s1 asserts a single read mid-burst -> s1_waitrequest high at most MAX_HOLD cycles, then one s1 accept, then s0 resumes; no dropped or duplicated s0 accepts.
- Assert reset_n low the cycle after an s1 read accept -> s1_readdatavalid never pulses; after release all outputs are 0 and the first contention grants s0.
